depar_seg_merge: RTL and testbench

// - Deparser output stage: reassembles each packet into one AXI-Stream (m_axis_*).
// - Sources: segment 1 (fst FIFO), segment 2 (snd FIFO), segments 3..N (seg FIFO).
// - fst/snd segments already carry the PHV write-back; segments 3..N pass through untouched.
// - Discards packets whose first-segment tuser drop bit is set; keeps packet and drop counters.

---
 rtl/depar_pkg.sv | 26 ++
 rtl/depar_axis_out_reg.sv | 29 ++
 rtl/depar_seg_merge.sv | 186 ++++++++++++++++++
 tb/tb_depar_seg_merge.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/depar_pkg.sv
// Shared deparser types: FSM state encoding and the segment beat layout.
// Also used by the segment-split stage, so keep the beat field order stable.
package depar_pkg;

    localparam int DEPAR_DATA_WIDTH  = 512;
    localparam int DEPAR_TUSER_WIDTH = 128;

    typedef enum logic [1:0] {
        SEND_FST  = 2'd0,
        SEND_SND  = 2'd1,
        FLUSH_SEG = 2'd2
    } depar_state_t;

    typedef struct packed {
        logic [DEPAR_DATA_WIDTH-1:0]   tdata;
        logic [DEPAR_TUSER_WIDTH-1:0]  tuser;
        logic [DEPAR_DATA_WIDTH/8-1:0] tkeep;
        logic                          tlast;
    } depar_beat_t;

    // Flattened width of a beat for arbitrary data/tuser widths.
    function automatic int depar_beat_width(input int dw, input int uw);
        return dw + uw + dw / 8 + 1;
    endfunction

endpackage

// File: rtl/depar_axis_out_reg.sv
// One-entry AXI-Stream output register; refills whenever empty or being drained.
module depar_axis_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         tready,
    output logic [W-1:0] dout,
    output logic         tvalid,
    output logic         load_ok
);

    assign load_ok = !tvalid || tready;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            dout   <= '0;
            tvalid <= 1'b0;
        end else if (load_ok) begin
            tvalid <= load;
            if (load) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/depar_seg_merge.sv
// Deparser output stage: merges fst/snd/seg FIFOs into one stream, discards flagged packets.
//   state     | meaning
//   SEND_FST  | waiting for / consuming segment 1 (and the snd dummy on 1-segment packets)
//   SEND_SND  | consuming segment 2
//   FLUSH_SEG | passing segments 3..N through until tlast
module depar_seg_merge
    import depar_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = DEPAR_DATA_WIDTH,
    parameter int C_AXIS_TUSER_WIDTH = DEPAR_TUSER_WIDTH,
    parameter int C_DROP_BIT         = 0,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                            clk,
    input  logic                            aresetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    fst_fifo_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   fst_fifo_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  fst_fifo_tkeep,
    input  logic                            fst_fifo_tlast,
    input  logic                            fst_fifo_empty,
    output logic                            fst_fifo_rd_en,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    snd_fifo_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   snd_fifo_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  snd_fifo_tkeep,
    input  logic                            snd_fifo_tlast,
    input  logic                            snd_fifo_empty,
    output logic                            snd_fifo_rd_en,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    seg_fifo_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   seg_fifo_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  seg_fifo_tkeep,
    input  logic                            seg_fifo_tlast,
    input  logic                            seg_fifo_empty,
    output logic                            seg_fifo_rd_en,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,

    output logic [C_CNT_WIDTH-1:0]          pkt_cnt,
    output logic [C_CNT_WIDTH-1:0]          drop_cnt
);

    localparam int BW = depar_beat_width(C_AXIS_DATA_WIDTH, C_AXIS_TUSER_WIDTH);

    depar_state_t state;
    logic         drop_flag;
    logic         load_ok;
    logic         emit;
    logic         fst_pop;
    logic         snd_pop;
    logic         seg_pop;
    logic         fst_drop;
    logic [BW-1:0] fst_beat;
    logic [BW-1:0] snd_beat;
    logic [BW-1:0] seg_beat;
    logic [BW-1:0] emit_beat;
    logic [BW-1:0] out_beat;

    assign fst_beat = {fst_fifo_tdata, fst_fifo_tuser, fst_fifo_tkeep, fst_fifo_tlast};
    assign snd_beat = {snd_fifo_tdata, snd_fifo_tuser, snd_fifo_tkeep, snd_fifo_tlast};
    assign seg_beat = {seg_fifo_tdata, seg_fifo_tuser, seg_fifo_tkeep, seg_fifo_tlast};
    assign fst_drop = fst_fifo_tuser[C_DROP_BIT];

    // Discarded beats never touch the output register, so they pop without load_ok.
    always_comb begin
        fst_pop   = 1'b0;
        snd_pop   = 1'b0;
        seg_pop   = 1'b0;
        emit      = 1'b0;
        emit_beat = fst_beat;
        case (state)
            SEND_FST: begin
                if (!fst_fifo_empty) begin
                    if (fst_drop) begin
                        if (!fst_fifo_tlast) begin
                            fst_pop = 1'b1;
                        end else if (!snd_fifo_empty) begin
                            fst_pop = 1'b1;
                            snd_pop = 1'b1;
                        end
                    end else if (fst_fifo_tlast) begin
                        if (!snd_fifo_empty && load_ok) begin
                            fst_pop = 1'b1;
                            snd_pop = 1'b1;
                            emit    = 1'b1;
                        end
                    end else if (load_ok) begin
                        fst_pop = 1'b1;
                        emit    = 1'b1;
                    end
                end
            end
            SEND_SND: begin
                if (!snd_fifo_empty && (load_ok || drop_flag)) begin
                    snd_pop   = 1'b1;
                    emit      = !drop_flag;
                    emit_beat = snd_beat;
                end
            end
            FLUSH_SEG: begin
                if (!seg_fifo_empty && (load_ok || drop_flag)) begin
                    seg_pop   = 1'b1;
                    emit      = !drop_flag;
                    emit_beat = seg_beat;
                end
            end
            default: ;
        endcase
    end

    assign fst_fifo_rd_en = fst_pop;
    assign snd_fifo_rd_en = snd_pop;
    assign seg_fifo_rd_en = seg_pop;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state     <= SEND_FST;
            drop_flag <= 1'b0;
            pkt_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                pkt_cnt <= pkt_cnt + C_CNT_WIDTH'(1);
            end
            case (state)
                SEND_FST: begin
                    if (fst_pop) begin
                        if (fst_fifo_tlast) begin
                            if (fst_drop) begin
                                drop_cnt <= drop_cnt + C_CNT_WIDTH'(1);
                            end
                        end else begin
                            state     <= SEND_SND;
                            drop_flag <= fst_drop;
                        end
                    end
                end
                SEND_SND: begin
                    if (snd_pop) begin
                        if (snd_fifo_tlast) begin
                            state     <= SEND_FST;
                            drop_flag <= 1'b0;
                            if (drop_flag) begin
                                drop_cnt <= drop_cnt + C_CNT_WIDTH'(1);
                            end
                        end else begin
                            state <= FLUSH_SEG;
                        end
                    end
                end
                FLUSH_SEG: begin
                    if (seg_pop && seg_fifo_tlast) begin
                        state     <= SEND_FST;
                        drop_flag <= 1'b0;
                        if (drop_flag) begin
                            drop_cnt <= drop_cnt + C_CNT_WIDTH'(1);
                        end
                    end
                end
                default: state <= SEND_FST;
            endcase
        end
    end

    depar_axis_out_reg #(
        .W(BW)
    ) u_out_reg (
        .clk     (clk),
        .aresetn (aresetn),
        .load    (emit),
        .din     (emit_beat),
        .tready  (m_axis_tready),
        .dout    (out_beat),
        .tvalid  (m_axis_tvalid),
        .load_ok (load_ok)
    );

    assign {m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast} = out_beat;

endmodule

// File: tb/tb_depar_seg_merge.sv
// Directed bench for depar_seg_merge: queue-modelled FWFT FIFOs, captured output beats.
module tb_depar_seg_merge;
    import depar_pkg::*;

    localparam int DW = 512;
    localparam int UW = 128;
    localparam int KW = DW / 8;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] fst_fifo_tdata, snd_fifo_tdata, seg_fifo_tdata, m_axis_tdata;
    logic [UW-1:0] fst_fifo_tuser, snd_fifo_tuser, seg_fifo_tuser, m_axis_tuser;
    logic [KW-1:0] fst_fifo_tkeep, snd_fifo_tkeep, seg_fifo_tkeep, m_axis_tkeep;
    logic fst_fifo_tlast, snd_fifo_tlast, seg_fifo_tlast, m_axis_tlast;
    logic fst_fifo_empty, snd_fifo_empty, seg_fifo_empty;
    logic fst_fifo_rd_en, snd_fifo_rd_en, seg_fifo_rd_en;
    logic m_axis_tvalid, m_axis_tready;
    logic [31:0] pkt_cnt, drop_cnt;

    depar_seg_merge dut (
        .clk(clk), .aresetn(aresetn),
        .fst_fifo_tdata(fst_fifo_tdata), .fst_fifo_tuser(fst_fifo_tuser),
        .fst_fifo_tkeep(fst_fifo_tkeep), .fst_fifo_tlast(fst_fifo_tlast),
        .fst_fifo_empty(fst_fifo_empty), .fst_fifo_rd_en(fst_fifo_rd_en),
        .snd_fifo_tdata(snd_fifo_tdata), .snd_fifo_tuser(snd_fifo_tuser),
        .snd_fifo_tkeep(snd_fifo_tkeep), .snd_fifo_tlast(snd_fifo_tlast),
        .snd_fifo_empty(snd_fifo_empty), .snd_fifo_rd_en(snd_fifo_rd_en),
        .seg_fifo_tdata(seg_fifo_tdata), .seg_fifo_tuser(seg_fifo_tuser),
        .seg_fifo_tkeep(seg_fifo_tkeep), .seg_fifo_tlast(seg_fifo_tlast),
        .seg_fifo_empty(seg_fifo_empty), .seg_fifo_rd_en(seg_fifo_rd_en),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic [31:0]   id;
        logic [KW-1:0] keep;
        logic          last;
    } obs_t;

    depar_beat_t fst_q[$];
    depar_beat_t snd_q[$];
    depar_beat_t seg_q[$];
    obs_t        out_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int fst_pops, snd_pops, seg_pops, pair_pops, bad_rd, stall_viol;
    logic          stalled = 1'b0;
    logic [DW-1:0] stall_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic depar_beat_t mk(input logic [31:0] id, input logic last,
                                       input logic drop, input logic [KW-1:0] keep);
        depar_beat_t b;
        b.tdata = DW'(id);
        b.tuser = UW'(drop);
        b.tkeep = keep;
        b.tlast = last;
        return b;
    endfunction

    task automatic refresh();
        fst_fifo_empty = (fst_q.size() == 0);
        snd_fifo_empty = (snd_q.size() == 0);
        seg_fifo_empty = (seg_q.size() == 0);
        {fst_fifo_tdata, fst_fifo_tuser, fst_fifo_tkeep, fst_fifo_tlast} =
            fst_fifo_empty ? '0 : fst_q[0];
        {snd_fifo_tdata, snd_fifo_tuser, snd_fifo_tkeep, snd_fifo_tlast} =
            snd_fifo_empty ? '0 : snd_q[0];
        {seg_fifo_tdata, seg_fifo_tuser, seg_fifo_tkeep, seg_fifo_tlast} =
            seg_fifo_empty ? '0 : seg_q[0];
    endtask

    task automatic clear_stats();
        fst_pops = 0; snd_pops = 0; seg_pops = 0; pair_pops = 0;
        out_q.delete();
    endtask

    task automatic tick();
        logic pf, ps, pg;
        obs_t o;
        @(negedge clk);
        pf = fst_fifo_rd_en; ps = snd_fifo_rd_en; pg = seg_fifo_rd_en;
        if ((pf && fst_q.size() == 0) || (ps && snd_q.size() == 0) || (pg && seg_q.size() == 0))
            bad_rd++;
        if (pg && (pf || ps)) bad_rd++;
        if (pf && ps) pair_pops++;
        if (stalled && (!m_axis_tvalid || m_axis_tdata !== stall_data)) stall_viol++;
        stalled    = m_axis_tvalid && !m_axis_tready;
        stall_data = m_axis_tdata;
        if (m_axis_tvalid && m_axis_tready) begin
            o.id = m_axis_tdata[31:0]; o.keep = m_axis_tkeep; o.last = m_axis_tlast;
            out_q.push_back(o);
        end
        @(posedge clk);
        #1;
        if (pf && fst_q.size() > 0) begin void'(fst_q.pop_front()); fst_pops++; end
        if (ps && snd_q.size() > 0) begin void'(snd_q.pop_front()); snd_pops++; end
        if (pg && seg_q.size() > 0) begin void'(seg_q.pop_front()); seg_pops++; end
        refresh();
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((fst_q.size() != 0 || snd_q.size() != 0 || seg_q.size() != 0 || m_axis_tvalid)
               && k < 50) begin
            tick();
            k++;
        end
        tick();
        check({tag, "_drain_timeout"}, 64'(k >= 50), 64'd0);
    endtask

    task automatic check_out(input string tag, input int idx, input logic [31:0] id,
                             input logic last);
        if (idx < out_q.size()) begin
            check({tag, "_id"}, 64'(out_q[idx].id), 64'(id));
            check({tag, "_last"}, 64'(out_q[idx].last), 64'(last));
        end else begin
            check({tag, "_missing"}, 64'd0, 64'd1);
        end
    endtask

    localparam logic [KW-1:0] KEEP_ALL = '1;
    logic [1:0] rdy_pat [4];

    initial begin
        bad_rd = 0; stall_viol = 0;
        m_axis_tready = 1'b1;
        refresh();
        clear_stats();
        repeat (3) tick();
        aresetn = 1'b1;
        tick();

        // reset state
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata[63:0]), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_state", 64'(dut.state), 64'(SEND_FST));

        // 1-segment packet with snd dummy
        clear_stats();
        fst_q.push_back(mk(32'hA1, 1'b1, 1'b0, KW'(64'hFFFF)));
        snd_q.push_back(mk(32'hD0, 1'b1, 1'b0, KEEP_ALL));
        refresh();
        drain("t1");
        check("t1_beats", 64'(out_q.size()), 64'd1);
        check_out("t1_b0", 0, 32'hA1, 1'b1);
        if (out_q.size() > 0) check("t1_keep", 64'(out_q[0].keep), 64'hFFFF);
        check("t1_pair_pop", 64'(pair_pops), 64'd1);
        check("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // 2-segment packet
        clear_stats();
        fst_q.push_back(mk(32'hB1, 1'b0, 1'b0, KEEP_ALL));
        snd_q.push_back(mk(32'hB2, 1'b1, 1'b0, KEEP_ALL));
        refresh();
        drain("t2");
        check("t2_beats", 64'(out_q.size()), 64'd2);
        check_out("t2_b0", 0, 32'hB1, 1'b0);
        check_out("t2_b1", 1, 32'hB2, 1'b1);
        check("t2_seg_pops", 64'(seg_pops), 64'd0);
        check("t2_pkt_cnt", 64'(pkt_cnt), 64'd2);

        // 4-segment packet with tready 1,0,0,1
        clear_stats();
        fst_q.push_back(mk(32'hC1, 1'b0, 1'b0, KEEP_ALL));
        snd_q.push_back(mk(32'hC2, 1'b0, 1'b0, KEEP_ALL));
        seg_q.push_back(mk(32'hC3, 1'b0, 1'b0, KEEP_ALL));
        seg_q.push_back(mk(32'hC4, 1'b1, 1'b0, KEEP_ALL));
        refresh();
        rdy_pat[0] = 2'd1; rdy_pat[1] = 2'd0; rdy_pat[2] = 2'd0; rdy_pat[3] = 2'd1;
        for (int i = 0; i < 4; i++) begin
            m_axis_tready = rdy_pat[i][0];
            tick();
        end
        m_axis_tready = 1'b1;
        drain("t4");
        check("t4_beats", 64'(out_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check_out($sformatf("t4_b%0d", i), i, 32'hC1 + 32'(i), (i == 3));
        check("t4_pops", 64'({fst_pops[7:0], snd_pops[7:0], seg_pops[7:0]}), 64'h010102);
        check("t4_stall_stable", 64'(stall_viol), 64'd0);
        check("t4_pkt_cnt", 64'(pkt_cnt), 64'd3);

        // dropped 3-segment packet followed by a clean 2-segment packet
        clear_stats();
        fst_q.push_back(mk(32'hE1, 1'b0, 1'b1, KEEP_ALL));
        snd_q.push_back(mk(32'hE2, 1'b0, 1'b0, KEEP_ALL));
        seg_q.push_back(mk(32'hE3, 1'b1, 1'b0, KEEP_ALL));
        fst_q.push_back(mk(32'hF1, 1'b0, 1'b0, KEEP_ALL));
        snd_q.push_back(mk(32'hF2, 1'b1, 1'b0, KEEP_ALL));
        refresh();
        drain("t5");
        check("t5_beats", 64'(out_q.size()), 64'd2);
        check_out("t5_b0", 0, 32'hF1, 1'b0);
        check_out("t5_b1", 1, 32'hF2, 1'b1);
        check("t5_pops", 64'(fst_pops + snd_pops + seg_pops), 64'd5);
        check("t5_drop_cnt", 64'(drop_cnt), 64'd1);
        check("t5_pkt_cnt", 64'(pkt_cnt), 64'd4);

        // snd FIFO empty for a while after segment 1
        clear_stats();
        fst_q.push_back(mk(32'h61, 1'b0, 1'b0, KEEP_ALL));
        refresh();
        repeat (6) tick();
        check("t6_beats", 64'(out_q.size()), 64'd1);
        check_out("t6_b0", 0, 32'h61, 1'b0);
        check("t6_snd_pops", 64'(snd_pops), 64'd0);
        check("t6_state", 64'(dut.state), 64'(SEND_SND));
        snd_q.push_back(mk(32'h62, 1'b1, 1'b0, KEEP_ALL));
        refresh();
        drain("t6");
        check_out("t6_b1", 1, 32'h62, 1'b1);
        check("t6_pkt_cnt", 64'(pkt_cnt), 64'd5);

        // reset in the middle of a 4-segment packet
        clear_stats();
        fst_q.push_back(mk(32'h71, 1'b0, 1'b0, KEEP_ALL));
        snd_q.push_back(mk(32'h72, 1'b0, 1'b0, KEEP_ALL));
        seg_q.push_back(mk(32'h73, 1'b0, 1'b0, KEEP_ALL));
        seg_q.push_back(mk(32'h74, 1'b1, 1'b0, KEEP_ALL));
        refresh();
        repeat (2) tick();
        aresetn = 1'b0;
        fst_q.delete(); snd_q.delete(); seg_q.delete();
        refresh();
        tick();
        aresetn = 1'b1;
        stalled = 1'b0;
        check("t7_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t7_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("t7_drop_cnt", 64'(drop_cnt), 64'd0);
        check("t7_state", 64'(dut.state), 64'(SEND_FST));
        clear_stats();
        fst_q.push_back(mk(32'h81, 1'b1, 1'b0, KEEP_ALL));
        snd_q.push_back(mk(32'hD1, 1'b1, 1'b0, KEEP_ALL));
        refresh();
        drain("t7");
        check("t7_beats", 64'(out_q.size()), 64'd1);
        check_out("t7_b0", 0, 32'h81, 1'b1);
        check("t7_pkt_cnt_after", 64'(pkt_cnt), 64'd1);

        check("rd_en_rules", 64'(bad_rd), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
